// File: rtl/reset_sequencer.sv
// Stage-staggered reset generator: holds datapath and fetch in reset after stable,
// releases datapath first, then fetch; accepts warm-reset requests and counts them.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned STAGGER_CYCLES = 2,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stable,
    input  logic                 rst_req,
    output logic                 rst_ack,
    output logic                 dp_rst_n,
    output logic                 fe_rst_n,
    output logic                 core_ready,
    output logic [CNT_WIDTH-1:0] rst_count
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_STAGGER = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 dp_rst_n_q, dp_rst_n_d;
    logic                 fe_rst_n_q, fe_rst_n_d;
    logic                 core_ready_q, core_ready_d;
    logic                 rst_ack_q, rst_ack_d;
    logic [CNT_WIDTH-1:0] rst_count_q, rst_count_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dp_rst_n_d  = dp_rst_n_q;
        fe_rst_n_d  = fe_rst_n_q;
        rst_ack_d   = 1'b0;
        rst_count_d = rst_count_q;

        case (state_q)
            ST_ASSERT: begin
                dp_rst_n_d = 1'b0;
                fe_rst_n_d = 1'b0;
                cnt_d      = '0;
                if (stable) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stable) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    // With no stagger, fetch is released together with the datapath.
                    cnt_d      = '0;
                    dp_rst_n_d = 1'b1;
                    if (STAGGER_CYCLES == 0) begin
                        fe_rst_n_d = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        state_d = ST_STAGGER;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STAGGER: begin
                if (!stable) begin
                    state_d    = ST_ASSERT;
                    cnt_d      = '0;
                    dp_rst_n_d = 1'b0;
                    fe_rst_n_d = 1'b0;
                end else if (cnt_q == CW'(STAGGER_CYCLES - 1)) begin
                    cnt_d      = '0;
                    fe_rst_n_d = 1'b1;
                    state_d    = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // Power loss and a warm request collapse into a single reset event.
                if (!stable || rst_req) begin
                    state_d     = ST_ASSERT;
                    cnt_d       = '0;
                    dp_rst_n_d  = 1'b0;
                    fe_rst_n_d  = 1'b0;
                    rst_ack_d   = rst_req;
                    rst_count_d = rst_count_q + CNT_WIDTH'(1);
                end
            end
        endcase

        core_ready_d = dp_rst_n_d & fe_rst_n_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= '0;
            dp_rst_n_q   <= 1'b0;
            fe_rst_n_q   <= 1'b0;
            core_ready_q <= 1'b0;
            rst_ack_q    <= 1'b0;
            rst_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dp_rst_n_q   <= dp_rst_n_d;
            fe_rst_n_q   <= fe_rst_n_d;
            core_ready_q <= core_ready_d;
            rst_ack_q    <= rst_ack_d;
            rst_count_q  <= rst_count_d;
        end
    end

    assign rst_ack    = rst_ack_q;
    assign dp_rst_n   = dp_rst_n_q;
    assign fe_rst_n   = fe_rst_n_q;
    assign core_ready = core_ready_q;
    assign rst_count  = rst_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized scoreboard bench for reset_sequencer: default and minimal-parameter
// instances share rst/stable, each with its own requester and reference model.
module tb_reset_sequencer;

    localparam int NCYC = 2500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, stable;
    logic       req0, req1;
    logic       ack0, dp0, fe0, rdy0;
    logic       ack1, dp1, fe1, rdy1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    reset_sequencer #(.HOLD_CYCLES(4), .STAGGER_CYCLES(2), .CNT_WIDTH(8)) u_def (
        .clk(clk), .rst(rst), .stable(stable), .rst_req(req0), .rst_ack(ack0),
        .dp_rst_n(dp0), .fe_rst_n(fe0), .core_ready(rdy0), .rst_count(cnt0)
    );

    reset_sequencer #(.HOLD_CYCLES(1), .STAGGER_CYCLES(0), .CNT_WIDTH(2)) u_min (
        .clk(clk), .rst(rst), .stable(stable), .rst_req(req1), .rst_ack(ack1),
        .dp_rst_n(dp1), .fe_rst_n(fe1), .core_ready(rdy1), .rst_count(cnt1)
    );

    // Reference model: good = consecutive stable edges since the sequence began
    // (-1 while waiting for stable); release points are thresholds on it.
    int   H[2] = '{4, 1};
    int   S[2] = '{2, 0};
    int   W[2] = '{8, 2};
    int   good[2];
    int   evt[2];
    logic mack[2];

    typedef struct packed {
        logic [1:0] dp;
        logic [1:0] fe;
        logic [1:0] ack;
        logic [7:0] c0;
        logic [1:0] c1;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic model_step(input int i, input logic r, input logic st, input logic rq);
        mack[i] = 1'b0;
        if (r) begin
            good[i] = -1;
            evt[i]  = 0;
        end else if (good[i] < 0) begin
            if (st) good[i] = 0;
        end else if (good[i] < H[i] + S[i]) begin
            good[i] = st ? good[i] + 1 : -1;
        end else if (!st || rq) begin
            good[i] = -1;
            evt[i]  = (evt[i] + 1) % (1 << W[i]);
            mack[i] = rq;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per clock, compared mid-cycle.
    initial begin
        exp_t e;
        logic pa0, pa1;
        pa0 = 1'b0;
        pa1 = 1'b0;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dp_rst_n[def]",   {7'd0, dp0},  {7'd0, e.dp[0]});
                chk("fe_rst_n[def]",   {7'd0, fe0},  {7'd0, e.fe[0]});
                chk("core_ready[def]", {7'd0, rdy0}, {7'd0, e.fe[0]});
                chk("rst_ack[def]",    {7'd0, ack0}, {7'd0, e.ack[0]});
                chk("rst_count[def]",  cnt0,         e.c0);
                chk("dp_rst_n[min]",   {7'd0, dp1},  {7'd0, e.dp[1]});
                chk("fe_rst_n[min]",   {7'd0, fe1},  {7'd0, e.fe[1]});
                chk("core_ready[min]", {7'd0, rdy1}, {7'd0, e.fe[1]});
                chk("rst_ack[min]",    {7'd0, ack1}, {7'd0, e.ack[1]});
                chk("rst_count[min]",  {6'd0, cnt1}, {6'd0, e.c1});
                chk("fe_without_dp[def]", {7'd0, fe0 & ~dp0}, 8'd0);
                chk("ack_twice[def]",     {7'd0, pa0 & ack0}, 8'd0);
                chk("ack_twice[min]",     {7'd0, pa1 & ack1}, 8'd0);
                pa0 = ack0;
                pa1 = ack1;
            end
        end
    end

    // Driver: applies inputs, advances the model at each edge and queues the expectation.
    initial begin
        exp_t e;
        rst    = 1'b1;
        stable = 1'b1;
        req0   = 1'b0;
        req1   = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            model_step(0, rst, stable, req0);
            model_step(1, rst, stable, req1);
            for (int i = 0; i < 2; i++) begin
                e.dp[i]  = (good[i] >= H[i]);
                e.fe[i]  = (good[i] >= H[i] + S[i]);
                e.ack[i] = mack[i];
            end
            e.c0 = 8'(evt[0]);
            e.c1 = 2'(evt[1]);
            q.push_back(e);
            #1;
            rst = (c < 2) || (c >= 300 && c < 303) || ($urandom_range(0, 299) == 0);
            if (c < 40)
                stable = 1'b1;
            else if ((c >= 40 && c < 50) || (c >= 303 && c < 313))
                stable = 1'b0;
            else
                stable = ($urandom_range(0, 15) != 0);
            req0 = mack[0] ? 1'b0 : (req0 || (c >= 20 && $urandom_range(0, 9) == 0));
            req1 = mack[1] ? 1'b0 : (req1 || (c >= 20 && $urandom_range(0, 9) == 0));
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
